pending_encoder8to3: RTL and testbench
======================================

# pending_encoder8to3

Sequential 8-to-3 priority encoder: the inverse of the 3-to-8 decoder. It latches one-hot or multi-hot event lines on an 8-bit bus, numbered the same way as the decoder outputs (bit i asserted ⇔ code i). It presents the highest-numbered pending event as a registered 3-bit code with a valid/ack handshake, and clears each event once it is acknowledged. It sits at the collection end of a decoder-driven select bus, turning returned event lines back into codes for the control logic.

## Interface
- No parameters; widths fixed (8 event lines, 3-bit code).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- En  input  1  capture enable; when 0, Y is ignored (no new pending bits, no drops counted).
- Y  input  [0:7]  event lines, level-sampled each clk edge; Y[i] requests code i.
- W  output  [2:0]  encoded index of the granted event; valid only while V=1.
- V  output  1  code valid.
- Ack  input  1  consumer acknowledge; meaningful only while V=1.
- Pend  output  [0:7]  current pending register (debug/status).
- Drop  output  [3:0]  saturating count of cycles in which a captured request hit an already-pending bit.

## Operation
- Pending register P[0:7]. Each edge: P ← (P & ~C) | (En ? Y : 0).
  - C is the one-hot clear of code W, applied only on an edge where V=1 and Ack=1.
  - Set wins over clear: if Y[W]=1 on the ack edge with En=1, bit W stays pending.
- Priority: the highest index wins (Y[7] highest, Y[0] lowest). The code is computed from P (registered), never from raw Y.
- FSM, two states:
  - IDLE (V=0): on an edge with P≠0, load W ← highest set index of P, V ← 1, go to HOLD. If P=0, stay.
  - HOLD (V=1): W is frozen; new higher-priority arrivals do not pre-empt. On an edge with Ack=1, clear P[W], V ← 0, go to IDLE. With Ack=0, stay.
- Ack while in IDLE is ignored.
- Drop counter increments by 1 on any edge where En=1 and (Y & P & ~C)≠0. It saturates at 15 and is cleared only by rst.
- En=0 does not affect a grant in progress; HOLD/Ack proceed normally.

## Timing
- Reset (async, immediate): P=0, W=3'b000, V=0, state IDLE, Drop=0. Y is not captured while rst=1.
- Capture latency: Y high before edge k → P bit set after edge k → V=1 with W after edge k+1. Minimum 2 edges from request to valid.
- Handshake: a transfer occurs on an edge where V=1 and Ack=1. V falls after that edge, and the earliest next V=1 is after the following edge. Back-to-back grants are therefore spaced at least 2 cycles apart.
- W and V are glitch-free registered outputs. W holds its last value while V=0.
- Simultaneous events on an ack edge:
  - Clear of bit W and capture of other bits both apply.
  - Re-request of bit W is retained and is not counted as a drop.
- Reset asserted mid-HOLD: V drops immediately, and the pending event is lost.
- The width of P is fixed at 8; no wrap-around exists. Drop never wraps.

## Test plan
- Reset: assert rst mid-sequence with P=8'hFF, V=1 → V=0, W=0, Pend=0, Drop=0 immediately; no capture until rst deasserts.
- Single event: En=1, pulse Y[5] for one cycle → Pend bit 5 set after edge 1, V=1 and W=5 after edge 2. Ack=1 for one edge → V=0, Pend=0.
- Priority and ordering: pulse Y[1], Y[3] and Y[6] in the same cycle, then ack each grant promptly → grants W=6, then 3, then 1, with V low for one cycle between grants.
- No pre-emption: hold V=1 with W=2 and Ack=0, then pulse Y[7] → W stays 2 until ack. The next grant is W=7.
- Drops and set-wins-clear:
  - Pulse Y[4] twice while bit 4 is pending → Drop=1.
  - Assert Y[4] on the ack edge of W=4 → bit 4 stays pending, Drop unchanged, and a new grant W=4 follows.
  - 20 drop cycles → Drop saturates at 15.
- Enable gating: En=0 with Y=8'hFF for 5 cycles → Pend=0, V=0, Drop=0. An in-progress grant still completes on Ack.

Source files
------------

// File: rtl/pending_encoder8to3.sv
// pending_encoder8to3: latches 8 event lines into a pending register and grants the
// highest-numbered pending event as a registered 3-bit code with a valid/ack handshake.
module pending_encoder8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [0:7] Y,
    output logic [2:0] W,
    output logic       V,
    input  logic       Ack,
    output logic [0:7] Pend,
    output logic [3:0] Drop
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0] state_q, state_d;
    logic [0:7] p_q, p_d, clr, cap;
    logic [2:0] w_q, w_d, hi;
    logic [3:0] drop_q, drop_d;
    always_comb begin
        hi = '0;
        for (int i = 0; i < 8; i++) hi = p_q[i] ? 3'(i) : hi;
        clr = '0;
        if (state_q == HOLD && Ack) clr[w_q] = 1'b1;
        cap = En ? Y : '0;
        // set wins over clear, so a re-request of the acked code survives
        p_d = (p_q & ~clr) | cap;
        drop_d = (|(cap & p_q & ~clr) && drop_q != 4'hF) ? drop_q + 4'd1 : drop_q;
        state_d = state_q;
        w_d = w_q;
        if (state_q == IDLE) begin
            state_d = |p_q ? HOLD : IDLE;
            w_d = |p_q ? hi : w_q;
        end else begin
            state_d = Ack ? IDLE : HOLD;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q <= '0;
            w_q <= '0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            w_q <= w_d;
            drop_q <= drop_d;
        end
    end
    assign W = w_q;
    assign V = (state_q == HOLD);
    assign Pend = p_q;
    assign Drop = drop_q;
endmodule

// File: tb/tb_pending_encoder8to3.sv
// tb_pending_encoder8to3: directed scenarios plus random traffic, checked every cycle
// against an index-based behavioural model of the pending/grant rules.
module tb_pending_encoder8to3;
    logic clk = 1'b0;
    logic rst, en, ack;
    logic [0:7] y;
    logic [2:0] w;
    logic v;
    logic [0:7] pend;
    logic [3:0] drop;
    int errors = 0;
    int checks = 0;
    bit m_p[8];
    int m_w = 0;
    bit m_v = 0;
    int m_drop = 0;

    pending_encoder8to3 dut (.clk(clk), .rst(rst), .En(en), .Y(y), .W(w), .V(v),
                             .Ack(ack), .Pend(pend), .Drop(drop));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:7] yb(input int i);
        logic [0:7] r;
        r = '0;
        r[i[2:0]] = 1'b1;
        return r;
    endfunction

    function automatic int model_pend();
        logic [0:7] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = m_p[i];
        return int'(r);
    endfunction

    // model: pending set of event indices, grant = largest index when idle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_p[i] = 0;
            m_w = 0;
            m_v = 0;
            m_drop = 0;
        end else begin
            bit nxt[8];
            bit hit;
            int cleared;
            cleared = (m_v && ack) ? m_w : -1;
            hit = 0;
            for (int i = 0; i < 8; i++) begin
                bit still;
                still = m_p[i] && (i != cleared);
                if (en && y[i] && still) hit = 1;
                nxt[i] = still || (en && y[i]);
            end
            if (hit && m_drop < 15) m_drop = m_drop + 1;
            if (!m_v) begin
                for (int i = 7; i >= 0; i--) if (m_p[i] && !m_v) begin
                    m_v = 1;
                    m_w = i;
                end
            end else if (ack) m_v = 0;
            for (int i = 0; i < 8; i++) m_p[i] = nxt[i];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("V", int'(v), int'(m_v));
            check("W", int'(w), m_w);
            check("Pend", int'(pend), model_pend());
            check("Drop", int'(drop), m_drop);
        end
    end

    task automatic cyc(input logic e, input logic [0:7] yy, input logic a);
        en = e;
        y = yy;
        ack = a;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        en = 0;
        y = '0;
        ack = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_V", int'(v), 0);
        check("reset_Pend", int'(pend), 0);
        // single event
        cyc(1, yb(5), 0);
        check("single_pend", int'(pend), int'(yb(5)));
        check("single_V_early", int'(v), 0);
        cyc(1, '0, 0);
        check("single_V", int'(v), 1);
        check("single_W", int'(w), 5);
        cyc(1, '0, 1);
        check("single_ackV", int'(v), 0);
        check("single_ackPend", int'(pend), 0);
        // priority ordering
        cyc(1, yb(1) | yb(3) | yb(6), 0);
        cyc(1, '0, 0);
        check("prio_W6", int'(w), 6);
        cyc(1, '0, 1);
        check("prio_gap", int'(v), 0);
        cyc(1, '0, 0);
        check("prio_W3", int'(w), 3);
        cyc(1, '0, 1);
        cyc(1, '0, 0);
        check("prio_W1", int'(w), 1);
        cyc(1, '0, 1);
        // no pre-emption
        cyc(1, yb(2), 0);
        cyc(1, '0, 0);
        cyc(1, yb(7), 0);
        check("nopre_W2", int'(w), 2);
        cyc(1, '0, 0);
        check("nopre_hold", int'(w), 2);
        cyc(1, '0, 1);
        cyc(1, '0, 0);
        check("nopre_W7", int'(w), 7);
        cyc(1, '0, 1);
        // drops and set-wins-clear
        cyc(1, yb(4), 0);
        cyc(1, yb(4), 0);
        check("drop_one", int'(drop), 1);
        check("drop_W4", int'(w), 4);
        cyc(1, yb(4), 1);
        check("swc_pend", int'(pend), int'(yb(4)));
        check("swc_drop", int'(drop), 1);
        cyc(1, '0, 0);
        check("swc_regrant", int'(w) * 2 + int'(v), 9);
        cyc(1, '0, 1);
        cyc(1, yb(0), 0);
        repeat (20) cyc(1, yb(0), 0);
        check("drop_sat", int'(drop), 15);
        cyc(1, '0, 1);
        // async reset mid-HOLD with everything pending
        cyc(1, 8'hFF, 0);
        cyc(1, '0, 0);
        check("pre_rst_V", int'(v), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_V", int'(v), 0);
        check("rst_W", int'(w), 0);
        check("rst_Pend", int'(pend), 0);
        check("rst_Drop", int'(drop), 0);
        en = 1;
        y = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_nocap", int'(pend), 0);
        rst = 1'b0;
        // enable gating
        repeat (5) cyc(0, 8'hFF, 0);
        check("gate_pend", int'(pend), 0);
        check("gate_V", int'(v), 0);
        check("gate_drop", int'(drop), 0);
        cyc(1, yb(3), 0);
        cyc(0, '0, 0);
        check("gate_W3", int'(w), 3);
        cyc(0, 8'hFF, 1);
        check("gate_ackV", int'(v), 0);
        check("gate_ackPend", int'(pend), 0);
        // random traffic
        for (int n = 0; n < 600; n++)
            cyc(($urandom % 4) != 0, 8'($urandom & $urandom & $urandom), 1'($urandom % 2));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
